wc_tile_sched: RTL and testbench

Tile scheduler for the F(5,4) Winograd convolution datapath `wc`. Accepts a 1-D sample stream and forms overlapping 8-sample input tiles with stride 5. Drives each tile onto the datapath and captures the 5 results after the fixed datapath latency. Returns the results on a backpressured output stream, one 5-sample tile per beat, with per-frame start/done control.

---
 rtl/wc_tile_sched.sv | 190 +++++++++++++++++++
 tb/tb_wc_tile_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wc_tile_sched.sv
// Tile scheduler for the F(5,4) Winograd datapath. Cuts an input sample stream into
// overlapping 8-sample tiles (stride 5), issues them to the datapath, captures the
// 5-sample results after LAT cycles and returns them on a backpressured stream.
// Optional feature: define WC_SCHED_PIPE_EN to treat the datapath as fully pipelined.
module wc_tile_sched #(
  parameter int unsigned DW          = 10,
  parameter int unsigned ZW          = 10,
  parameter int unsigned LAT         = 6,
  parameter int unsigned OFIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7:0]      n_tiles,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic [8*DW-1:0] wc_d,
  input  logic [5*ZW-1:0] wc_z,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5*ZW-1:0] out_data,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  localparam int unsigned AW = $clog2(OFIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = 5 * ZW + 1;
  localparam logic [CW:0] DepthC = (CW+1)'(OFIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StFill, StIssue, StWait, StDrain} state_e;

  state_e        state_q;
  logic [DW-1:0] win_q [8];
  logic [3:0]    win_cnt_q;
  logic [7:0]    tiles_left_q;
  logic [10:0]   samp_left_q;
  logic [LAT-1:0] tag_v_q;
  logic [LAT-1:0] tag_l_q;
  logic [CW-1:0] inflight_q;
  logic [CW-1:0] fifo_cnt_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [FW-1:0] mem_q [OFIFO_DEPTH];

  logic          credit;
  logic          issue;
  logic          accept;
  logic          push;
  logic          load;
  logic          fill_full;
  logic [CW:0]   used;

  // Credit, handshakes and window-full detection from registered state.
  always_comb begin
    // The output register counts as a FIFO slot so credit covers every stored tile.
    used      = {1'b0, fifo_cnt_q} + {1'b0, inflight_q} + {{CW{1'b0}}, out_valid};
    credit    = used < DepthC;
    issue     = (state_q == StIssue) && credit;
    // The window keeps collecting while the issued tile sits in wc_d.
    in_ready  = (samp_left_q != 11'd0) &&
                ((((state_q == StFill) || (state_q == StWait)) && (win_cnt_q != 4'd8)) || issue);
    accept    = in_valid && in_ready;
    push      = tag_v_q[LAT-1];
    load      = (fifo_cnt_q != '0) && (!out_valid || out_ready);
    fill_full = (win_cnt_q + {3'b000, accept}) == 4'd8;
  end

  // Control FSM, sample window, issue register and in-flight tags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      for (int i = 0; i < 8; i++) win_q[i] <= '0;
      win_cnt_q    <= 4'd0;
      tiles_left_q <= 8'd0;
      samp_left_q  <= 11'd0;
      tag_v_q      <= '0;
      tag_l_q      <= '0;
      inflight_q   <= '0;
      wc_d         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (issue) begin
        for (int i = 0; i < 8; i++) wc_d[(7-i)*DW +: DW] <= win_q[i];
        // Last three samples of this tile start the next window.
        for (int i = 0; i < 3; i++) win_q[i] <= win_q[i+5];
        if (accept) win_q[3] <= in_data;
        win_cnt_q    <= accept ? 4'd4 : 4'd3;
        tiles_left_q <= tiles_left_q - 8'd1;
      end else if (accept) begin
        win_q[win_cnt_q[2:0]] <= in_data;
        win_cnt_q             <= win_cnt_q + 4'd1;
      end
      if (accept) samp_left_q <= samp_left_q - 11'd1;

      tag_v_q[0] <= issue;
      tag_l_q[0] <= issue && (tiles_left_q == 8'd1);
      for (int i = 1; i < LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_l_q[i] <= tag_l_q[i-1];
      end

      case ({issue, push})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase

      case (state_q)
        StIdle: begin
          if (start) begin
            if (n_tiles == 8'd0) begin
              done <= 1'b1;
            end else begin
              busy         <= 1'b1;
              tiles_left_q <= n_tiles;
              samp_left_q  <= 11'(n_tiles) * 11'd5 + 11'd3;
              win_cnt_q    <= 4'd0;
              state_q      <= StFill;
            end
          end
        end
        StFill: begin
          if (fill_full) state_q <= StIssue;
        end
        StIssue: begin
          if (issue) begin
`ifdef WC_SCHED_PIPE_EN
            state_q <= (tiles_left_q == 8'd1) ? StDrain : StFill;
`else
            state_q <= StWait;
`endif
          end
        end
        StWait: begin
          if (push) begin
            if (tiles_left_q == 8'd0) state_q <= StDrain;
            else                      state_q <= fill_full ? StIssue : StFill;
          end
        end
        StDrain: begin
          if (out_valid && out_ready && out_last) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Result FIFO storage; capture happens on the LAT-th edge after issue.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wc_z, tag_l_q[LAT-1]};
  end

  // FIFO pointers and the registered output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (load) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        out_data  <= mem_q[rd_ptr_q][FW-1:1];
        out_last  <= mem_q[rd_ptr_q][0];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      case ({push, load})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_wc_tile_sched.sv
// Directed bench for wc_tile_sched with a stand-in datapath of latency LAT.
module tb_wc_tile_sched;

  localparam int unsigned DW    = 10;
  localparam int unsigned ZW    = 10;
  localparam int unsigned LAT   = 6;
  localparam int unsigned DEPTH = 8;
`ifdef WC_SCHED_PIPE_EN
  localparam int SPACING = 5;
`else
  localparam int SPACING = LAT + 1;
`endif

  logic            clk;
  logic            rst;
  logic            start;
  logic [7:0]      n_tiles;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [8*DW-1:0] wc_d;
  logic [5*ZW-1:0] wc_z;
  logic            out_valid;
  logic            out_ready;
  logic [5*ZW-1:0] out_data;
  logic            out_last;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;
  int smp [80];
  int cyc;

  logic [8*DW-1:0] v1;
  logic [8*DW-1:0] v2;
  logic [5*ZW-1:0] z1;
  logic [5*ZW-1:0] z2;
  logic [5*ZW-1:0] zp [LAT-1];

  wc_tile_sched #(.DW(DW), .ZW(ZW), .LAT(LAT), .OFIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_tiles   (n_tiles),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .wc_d      (wc_d),
    .wc_z      (wc_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8*DW-1:0] pack8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int a [8];
    logic [8*DW-1:0] t;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    for (int i = 0; i < 8; i++) t[(7-i)*DW +: DW] = a[i][DW-1:0];
    return t;
  endfunction

  function automatic logic [5*ZW-1:0] pack5(input int a0, a1, a2, a3, a4);
    int a [5];
    logic [5*ZW-1:0] t;
    a = '{a0, a1, a2, a3, a4};
    for (int i = 0; i < 5; i++) t[(4-i)*ZW +: ZW] = a[i][ZW-1:0];
    return t;
  endfunction

  // Tile k of the current frame as the bench expects it on wc_d.
  function automatic logic [8*DW-1:0] exp_tile(input int k);
    logic [8*DW-1:0] t;
    int v;
    for (int i = 0; i < 8; i++) begin
      v = smp[(5*k+i) % 80];
      t[(7-i)*DW +: DW] = v[DW-1:0];
    end
    return t;
  endfunction

  // Stand-in datapath: known vectors map to their reference results, others to d[i]+d[i+3].
  function automatic logic [5*ZW-1:0] dp(input logic [8*DW-1:0] d);
    logic [5*ZW-1:0] y;
    if (d === v1) return z1;
    if (d === v2) return z2;
    for (int i = 0; i < 5; i++)
      y[(4-i)*ZW +: ZW] = ZW'(d[(7-i)*DW +: DW] + d[(4-i)*DW +: DW]);
    return y;
  endfunction

  // Datapath delay line: wc_z reflects the tile that sat on wc_d LAT edges earlier.
  always @(posedge clk) begin
    zp[0] <= dp(wc_d);
    for (int i = 1; i < LAT - 1; i++) zp[i] <= zp[i-1];
  end
  assign wc_z = zp[LAT-2];

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 80; i++) smp[i] = i;
  endtask

  // Runs one frame with continuous input; out_ready low for the first hold cycles.
  task automatic frame(input int n, input int hold, input int restart_at);
    int n_acc, n_iss, n_out, done_cnt, first_valid;
    int iss_cyc [16];
    logic [8*DW-1:0] prev;
    n_acc = 0; n_iss = 0; n_out = 0; done_cnt = 0; first_valid = -1;
    for (int i = 0; i < 16; i++) iss_cyc[i] = 0;
    prev      = wc_d;
    start     = 1'b1;
    n_tiles   = n[7:0];
    in_valid  = 1'b0;
    out_ready = (hold == 0);
    step();
    start = 1'b0;
    chk("in_ready_after_start", in_ready, 1);
    chk("busy_after_start", busy, 1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 1000) begin
      if (wc_d !== prev) begin
        if (n_iss < 16) begin
          iss_cyc[n_iss] = cyc;
          chk("issued_tile", wc_d, exp_tile(n_iss));
        end
        n_iss++;
        prev = wc_d;
      end
      if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (done === 1'b1) done_cnt++;
      if (hold > 0 && cyc == hold - 1)
        chk("stall_issue_count", n_iss, (n < DEPTH) ? n : DEPTH);
      start     = (cyc == restart_at);
      n_tiles   = 8'd5;
      out_ready = (cyc >= hold);
      in_valid  = 1'b1;
      in_data   = smp[n_acc % 80][DW-1:0];
      if (in_valid && in_ready) n_acc++;
      if (out_valid && out_ready) begin
        chk("out_data", out_data, dp(exp_tile(n_out)));
        chk("out_last", out_last, n_out == n - 1);
        n_out++;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    chk("frame_done_seen", done_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1) done_cnt++;
      if (in_valid && in_ready) n_acc++;
      step();
    end
    chk("done_pulse_width", done_cnt, 1);
    chk("samples_consumed", n_acc, 5 * n + 3);
    chk("tiles_out", n_out, n);
    chk("busy_after_done", busy, 0);
    chk("in_ready_idle", in_ready, 0);
    if (hold == 0) chk("issue_to_valid_latency", first_valid - iss_cyc[0], LAT + 1);
    if (n >= 3 && hold == 0) chk("issue_spacing", iss_cyc[2] - iss_cyc[1], SPACING);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    v1 = 80'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100;
    v2 = pack8(-19, -6, 3, -9, -12, 11, -4, 0);
    z1 = pack5(62, -42, -223, -242, -41);
    z2 = pack5(-183, -290, -182, -83, -570);
    start = 1'b0; n_tiles = 8'd0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wc_d", wc_d, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b1;
    step();

    // Single tile with reference vector 1.
    smp[0] = 2;   smp[1] = -10; smp[2] = 3;   smp[3] = 4;
    smp[4] = -13; smp[5] = -18; smp[6] = -16; smp[7] = -28;
    frame(1, 0, -1);

    // Zero-tile frame: done next cycle, no input taken.
    start = 1'b1; n_tiles = 8'd0; in_valid = 1'b1;
    step();
    start = 1'b0;
    chk("zero_tiles_done", done, 1);
    chk("zero_tiles_in_ready", in_ready, 0);
    chk("zero_tiles_busy", busy, 0);
    step();
    chk("zero_tiles_done_clear", done, 0);
    in_valid = 1'b0;

    // Overlapping tiles on a ramp, with a start pulse while busy.
    set_ramp();
    frame(3, 0, 3);

    // Backpressure: credit must stop issue at DEPTH tiles.
    frame(12, 150, -1);

    // Reset in the middle of a frame.
    set_ramp();
    start = 1'b1; n_tiles = 8'd3; out_ready = 1'b0;
    step();
    start = 1'b0; in_valid = 1'b1; k = 0;
    for (int i = 0; i < 25; i++) begin
      in_data = smp[k][DW-1:0];
      if (in_ready) k++;
      step();
    end
    chk("out_valid_before_reset", out_valid, 1);
    rst = 1'b0;
    #2;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_last", out_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_wc_d", wc_d, 0);
    chk("abort_out_data", out_data, 0);
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("abort_no_done", done, 0);

    // Second reference vector after the abort.
    smp[0] = -19; smp[1] = -6;  smp[2] = 3;  smp[3] = -9;
    smp[4] = -12; smp[5] = 11;  smp[6] = -4; smp[7] = 0;
    frame(1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
